// File: rtl/bp_fe_bp_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : bp_fe_bp_update_queue
// Description : In-order queue of outstanding branch predictions. Each entry
//               holds the predictor table index and the predicted direction.
//               When the oldest branch resolves, a registered update strobe
//               is sent to the predictor with the stored index and a flag
//               saying whether the stored prediction was correct.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_fe_bp_update_queue #(
  parameter bht_idx_width_p = "inv",
  parameter els_p           = 8,
  localparam ptr_width_lp   = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,

  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  output logic                       res_ready_o,

  input  logic                       flush_i,

  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [ptr_width_lp:0]      count_o
);

  localparam int                entry_width_lp = bht_idx_width_p + 1;
  localparam logic [ptr_width_lp:0] full_count_lp = (ptr_width_lp+1)'(els_p);

  // Pointer arithmetic relies on natural wrap, so depth must be a power of two.
  generate
    if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_depth
      $error("bp_fe_bp_update_queue: els_p must be a power of two >= 2");
    end
  endgenerate

  // Entry layout: {index, predicted taken}
  logic [entry_width_lp-1:0]  mem_q [els_p];
  logic [entry_width_lp-1:0]  mem_d [els_p];

  logic [ptr_width_lp-1:0]    wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]    rptr_q, rptr_d;
  logic [ptr_width_lp:0]      count_q, count_d;
  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
  logic                       correct_q, correct_d;

  logic                       enq;
  logic                       deq;
  logic [entry_width_lp-1:0]  head_entry;

  // Handshakes come only from the registered count, so there is no
  // combinational path from pred_v_i/res_v_i to the ready outputs.
  assign pred_ready_o = (count_q != full_count_lp);
  assign res_ready_o  = (count_q != '0);

  assign count_o   = count_q;
  assign w_v_o     = w_v_q;
  assign idx_w_o   = idx_w_q;
  assign correct_o = correct_q;

  assign head_entry = mem_q[rptr_q];

  // Next-state: enqueue/dequeue bookkeeping, flush override, update strobe.
  always_comb begin
    enq       = pred_v_i & pred_ready_o;
    deq       = res_v_i & res_ready_o;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    w_v_d     = 1'b0;
    idx_w_d   = idx_w_q;
    correct_d = correct_q;

    if (flush_i) begin
      // Flush discards everything, including any coincident pred/res.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[wptr_q] = {pred_idx_i, pred_taken_i};
        wptr_d        = wptr_q + ptr_width_lp'(1);
      end
      if (deq) begin
        rptr_d    = rptr_q + ptr_width_lp'(1);
        w_v_d     = 1'b1;
        idx_w_d   = head_entry[entry_width_lp-1:1];
        correct_d = (head_entry[0] == res_taken_i);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + (ptr_width_lp+1)'(1);
        2'b01:   count_d = count_q - (ptr_width_lp+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and output registers; reset wins over everything else.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      w_v_q     <= 1'b0;
      idx_w_q   <= '0;
      correct_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      w_v_q     <= w_v_d;
      idx_w_q   <= idx_w_d;
      correct_q <= correct_d;
    end
  end

  // Entry storage; contents are don't-care whenever count says they are empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: doc/bp_fe_bp_update_queue.md
BP_FE_BP_UPDATE_QUEUE -- requirements
Module: bp_fe_bp_update_queue

Interface
REQ-001 SHALL have parameter bht_idx_width_p, default "inv" (must be overridden), meaning the predictor table index width.
REQ-002 SHALL have parameter els_p, default 8, meaning the queue depth; legal values are powers of two >= 2.
REQ-003 SHALL derive localparam ptr_width_lp = log2(els_p).
REQ-004 SHALL have clk_i  input  1  clock; single clock domain, all state updates on the rising edge.
REQ-005 SHALL have reset_i  input  1  reset; synchronous and active-high.
REQ-006 SHALL have pred_v_i  input  1  a prediction was issued this cycle.
REQ-007 SHALL have pred_idx_i  input  bht_idx_width_p  table index used for that prediction.
REQ-008 SHALL have pred_taken_i  input  1  predicted direction (1 = taken).
REQ-009 SHALL have pred_ready_o  output  1  queue not full.
REQ-010 SHALL have res_v_i  input  1  the oldest outstanding branch resolved this cycle.
REQ-011 SHALL have res_taken_i  input  1  actual direction of that branch.
REQ-012 SHALL have res_ready_o  output  1  queue not empty.
REQ-013 SHALL have flush_i  input  1  discard all outstanding entries.
REQ-014 SHALL have w_v_o  output  1  update strobe to the predictor.
REQ-015 SHALL have idx_w_o  output  bht_idx_width_p  update index.
REQ-016 SHALL have correct_o  output  1  stored prediction matched the actual direction.
REQ-017 SHALL have count_o  output  ptr_width_lp+1  number of valid entries.

Function
REQ-018 SHALL store {pred_idx_i, pred_taken_i} at the write pointer on enqueue (pred_v_i & pred_ready_o), then advance the write pointer modulo els_p.
REQ-019 SHALL ignore pred_v_i when pred_ready_o=0; the entry is dropped and no state changes.
REQ-020 SHALL dequeue the oldest entry on resolve (res_v_i & res_ready_o), then advance the read pointer modulo els_p.
REQ-021 SHALL ignore res_v_i when res_ready_o=0; there is no update and no state change.
REQ-022 SHALL strictly preserve in-order FIFO order; pointer wrap from els_p-1 to 0 SHALL be seamless.
REQ-023 SHALL drive pred_ready_o = (count_o != els_p) and res_ready_o = (count_o != 0), both purely from registered count.
REQ-024 SHALL have no bypass: an entry enqueued in cycle N is resolvable no earlier than cycle N+1.
REQ-025 SHALL leave count_o unchanged and advance both pointers when enqueue and dequeue occur in the same cycle; this is legal whenever 0 < count < els_p.
REQ-026 SHALL, on a dequeue in cycle N, drive in cycle N+1 (registered, latency 1): w_v_o=1, idx_w_o = stored index, correct_o = (stored taken == res_taken_i).
REQ-027 SHALL hold w_v_o=0 in any cycle not following a dequeue, with idx_w_o/correct_o holding their last values.
REQ-028 SHALL give flush_i priority over enqueue and dequeue in the same cycle: pointers and count go to 0, and the coincident pred/res are discarded.
REQ-029 SHALL, on a flush cycle, drive w_v_o=0 in the following cycle.
REQ-030 SHALL allow back-to-back dequeues every cycle, producing one w_v_o pulse per dequeue.

Reset
REQ-031 SHALL, while reset_i=1, set read/write pointers to 0, count_o=0, w_v_o=0, idx_w_o=0 and correct_o=0, giving pred_ready_o=1 and res_ready_o=0 from the next cycle.
REQ-032 SHALL, on reset mid-operation, discard all entries and any pending output strobe; storage contents need not be cleared.
REQ-033 SHALL give reset priority over flush_i, pred_v_i and res_v_i.

Verification
REQ-034 Enqueue idx 5 taken, then 9 not-taken; resolve taken, taken -> w_v_o pulses on consecutive cycles with (idx 5, correct 1) then (idx 9, correct 0).
REQ-035 With els_p=8, enqueue 8 entries -> pred_ready_o=0 and count_o=8; a 9th pred_v_i is dropped; after 8 resolves, the indices emerge in original order and res_ready_o=0.
REQ-036 Fill 6 entries, then simultaneously enqueue and resolve for 10 cycles -> count_o stays 6, pointers wrap, and outputs remain in order.
REQ-037 Hold 4 entries, assert flush_i with res_v_i=1 -> next cycle w_v_o=0 and count_o=0; the next resolve attempt is ignored.
REQ-038 Assert reset_i for one cycle with 3 entries and a dequeue pending -> w_v_o=0, count_o=0, pred_ready_o=1, res_ready_o=0.
REQ-039 res_v_i while empty, together with pred_v_i (idx 3, taken) -> no w_v_o next cycle; count_o=1; the next res_v_i not-taken yields (idx 3, correct 0).
